// File: rtl/decommutator_pkg.sv
// Shared definitions for the decommutator block.
//   state_t       : fill state machine encoding (ALIGN discards, FILL stores)
//   idx_width()   : width of a branch index for M branches
//   start_branch(): branch that receives the first sample of every frame
package decommutator_pkg;

  typedef enum logic {
    ALIGN = 1'b0,
    FILL  = 1'b1
  } state_t;

  // Branch index width; M=2 still needs one bit.
  function automatic int idx_width(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  // Counter-clockwise fill starts at branch 0, clockwise at branch M-1.
  function automatic int start_branch(input int ccw, input int m);
    return (ccw != 0) ? 0 : m - 1;
  endfunction

endpackage

// File: rtl/decommutator_if.sv
// Sample-in / frame-out bundle of the decommutator.
//   i_ena     : global enable, everything freezes when low
//   i_sync    : frame restart
//   i_valid   : input sample strobe
//   i_data    : signed W-bit sample
//   o_data    : M*W-bit frame, branch k in bits [(k+1)*W-1 : k*W]
//   o_valid   : one-cycle slow-rate strobe, o_data just updated
//   o_phase   : branch the next accepted sample will be written to
//   dbg_state : current fill state (observation only)
// Handshake: a sample is taken on a rising edge where i_ena=1, i_valid=1
// and i_sync=0; there is no backpressure, the block is always ready.
interface decommutator_if
  import decommutator_pkg::*;
#(
  parameter int W = 4,
  parameter int M = 4
);
  localparam int IW = idx_width(M);

  logic           i_ena;
  logic           i_sync;
  logic           i_valid;
  logic [W-1:0]   i_data;
  logic [M*W-1:0] o_data;
  logic           o_valid;
  logic [IW-1:0]  o_phase;
  state_t         dbg_state;

  modport master (
    output i_ena, i_sync, i_valid, i_data,
    input  o_data, o_valid, o_phase, dbg_state
  );

  modport slave (
    input  i_ena, i_sync, i_valid, i_data,
    output o_data, o_valid, o_phase, dbg_state
  );

endinterface

// File: rtl/decommutator_slot_demux.sv
// Shadow frame register written one W-bit slot at a time.
//   clk, rst    : clock and asynchronous reset (shadow -> 0)
//   we          : write the slot selected by slot
//   slot        : branch index to write
//   data        : sample to store, bit-exact
//   shadow      : current shadow contents
//   shadow_next : shadow including this cycle's write, so a completing
//                 frame can be captured on the same edge as its last sample
module decommutator_slot_demux #(
  parameter int M  = 4,
  parameter int W  = 4,
  parameter int IW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [IW-1:0]  slot,
  input  logic [W-1:0]   data,
  output logic [M*W-1:0] shadow,
  output logic [M*W-1:0] shadow_next
);

  always_comb begin
    shadow_next = shadow;
    if (we) begin
      for (int k = 0; k < M; k++) begin
        if (slot == IW'(k)) begin
          shadow_next[k*W +: W] = data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (we) begin
      shadow <= shadow_next;
    end
  end

endmodule

// File: rtl/dff.sv
// Generic enabled register with asynchronous active-high clear.
//   clk, rst : clock and asynchronous reset (q -> 0)
//   en       : load enable
//   d, q     : data in / registered data out
module dff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/decommutator.sv
// Decimation-side input commutator: deals a serial signed sample stream
// onto M polyphase branches and presents one complete frame per M accepted
// samples together with a one-cycle slow-rate strobe.
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset
//   bus   : decommutator_if slave (enable, sync, sample in; frame,
//           strobe, next-branch index and fill state out)
module decommutator
  import decommutator_pkg::*;
#(
  parameter int gp_ccw               = 1,
  parameter int gp_idata_width       = 4,
  parameter int gp_decimation_factor = 4,
  parameter int gp_phase             = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  decommutator_if.slave  bus
);

  localparam int M  = gp_decimation_factor;
  localparam int W  = gp_idata_width;
  localparam int IW = idx_width(M);

  localparam logic [IW-1:0] START      = IW'(start_branch(gp_ccw, M));
  localparam logic [IW-1:0] LAST       = IW'((gp_ccw != 0) ? M - 1 : 0);
  localparam logic [IW-1:0] SKIP_LAST  = IW'((gp_phase == 0) ? 0 : gp_phase - 1);
  localparam state_t        INIT_STATE = (gp_phase == 0) ? FILL : ALIGN;

  state_t         state;
  logic [IW-1:0]  skip_cnt;
  logic [IW-1:0]  ptr;
  logic           valid_q;
  logic           accept;
  logic           slot_we;
  logic           complete;
  logic [M*W-1:0] shadow;
  logic [M*W-1:0] shadow_next;
  logic [M*W-1:0] frame;

  // Sync takes priority over a sample in the same cycle.
  assign accept   = bus.i_ena & bus.i_valid & ~bus.i_sync;
  assign slot_we  = accept & (state == FILL);
  assign complete = slot_we & (ptr == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= INIT_STATE;
      skip_cnt <= '0;
      ptr      <= START;
      valid_q  <= 1'b0;
    end else if (!bus.i_ena) begin
      // Dropping the strobe here suppresses a pending pulse instead of
      // letting it appear once the enable returns.
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.i_sync) begin
        state    <= INIT_STATE;
        skip_cnt <= '0;
        ptr      <= START;
      end else if (bus.i_valid) begin
        case (state)
          ALIGN: begin
            if (skip_cnt == SKIP_LAST) begin
              state    <= FILL;
              skip_cnt <= '0;
            end else begin
              skip_cnt <= skip_cnt + 1'b1;
            end
          end
          FILL: begin
            if (ptr == LAST) begin
              ptr     <= START;
              valid_q <= 1'b1;
            end else if (gp_ccw != 0) begin
              ptr <= ptr + 1'b1;
            end else begin
              ptr <= ptr - 1'b1;
            end
          end
          default: state <= INIT_STATE;
        endcase
      end
    end
  end

  decommutator_slot_demux #(
    .M  (M),
    .W  (W),
    .IW (IW)
  ) u_slot_demux (
    .clk         (i_clk),
    .rst         (i_rst),
    .we          (slot_we),
    .slot        (ptr),
    .data        (bus.i_data),
    .shadow      (shadow),
    .shadow_next (shadow_next)
  );

  // Output frame only changes on completion, so a partial shadow is never
  // visible downstream.
  dff #(
    .WIDTH (M*W)
  ) u_frame_reg (
    .clk (i_clk),
    .rst (i_rst),
    .en  (complete),
    .d   (shadow_next),
    .q   (frame)
  );

  assign bus.o_data    = frame;
  assign bus.o_valid   = valid_q & bus.i_ena;
  assign bus.o_phase   = ptr;
  assign bus.dbg_state = state;

endmodule

// File: doc/decommutator.md
Name: decommutator

Overview:
- Decimation-side input commutator for polyphase decimation filters; the counterpart of the interpolation-side output commutator.
- Takes a serial signed sample stream at the fast rate and deals consecutive samples onto gp_decimation_factor polyphase branches.
- Presents one complete parallel frame per M accepted samples, with a one-cycle slow-rate strobe that downstream polyphase sub-filters use as their enable.

Parameters:
- gp_ccw, 1: 1 = counter-clockwise fill (first sample of frame to branch 0, ascending); 0 = clockwise fill (first sample to branch M-1, descending).
- gp_idata_width, 4: sample width in bits, signed.
- gp_decimation_factor, 4: M, number of branches. Legal range 2..16.
- gp_phase, 0: number of accepted samples discarded after reset or sync, before the first frame starts. Legal range 0..M-1.

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  asynchronous active-high reset.
- i_ena  in  1  synchronous active-high global enable; when low, all state freezes and o_valid is 0.
- i_sync  in  1  frame restart; sampled only when i_ena=1.
- i_valid  in  1  input sample strobe.
- i_data  in  gp_idata_width  signed input sample.
- o_data  out  M*gp_idata_width  parallel frame; branch k occupies bits [(k+1)*W-1 : k*W].
- o_valid  out  1  one-cycle pulse when o_data updates (slow clock pulse).
- o_phase  out  clog2(M)  branch index the next accepted sample will be written to.

Behaviour:
- Reset: the clock and reset are already decided. There is one clock, i_clk. Reset i_rst is asynchronous and active-high. While i_rst is asserted, state machine = ALIGN (or FILL if gp_phase=0), skip counter=0, slot counter=0, frame shadow=0, o_data=0, o_valid=0, o_phase=start branch (0 for CCW, M-1 for CW).
- Accept condition: a sample is accepted when i_ena=1 and i_valid=1 and i_sync=0.
- State ALIGN:
  - Each accepted sample is discarded and the skip counter increments.
  - When the skip counter reaches gp_phase-1 on an accept, go to FILL on the next edge.
  - ALIGN is bypassed when gp_phase=0.
- State FILL:
  - Each accepted sample is written into the shadow slot selected by the slot pointer.
  - CCW: the pointer increments 0..M-1. CW: the pointer decrements M-1..0.
  - o_phase = current pointer value.
- Frame completion: on the accept that writes the last slot (pointer M-1 for CCW, 0 for CW):
  - o_data loads the whole shadow, including the sample just accepted, on that same edge.
  - o_valid = 1 for exactly the following cycle.
  - The pointer wraps to the start branch.
  - Latency from the last sample's accept edge to o_valid/o_data visible is 1 cycle.
- o_data holds its value between frames. A partially filled shadow is never visible on o_data.
- Back-to-back: with i_valid held high, o_valid pulses every M cycles; no bubbles occur at the wrap.
- i_valid=0 in FILL: the pointer holds and no slot is written.
- i_sync=1 (with i_ena=1):
  - Discard the partial frame; the pointer returns to the start branch and the skip counter is cleared.
  - Go to ALIGN (FILL if gp_phase=0). The sample present in the sync cycle is not accepted.
  - o_data is untouched.
  - If the sync cycle is also a completion cycle, sync wins and no o_valid is generated.
- i_ena=0: everything holds, o_valid forced 0, and a pending o_valid pulse is suppressed rather than delayed.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.
- Arithmetic: no arithmetic on the data path. Samples are stored bit-exact, sign preserved.

Decomposition:
- Shared package (dsp_pkg):
  - Function returning the start branch index from gp_ccw.
  - State encoding localparams ALIGN=1'b0, FILL=1'b1.
  - clog2-based index width constant.
- One natural sub-module: slot_demux. It takes the pointer plus write enable and writes one W-bit slot of the shadow register, parameterised by M and W. It is instantiated once.
- The existing dff is used for the o_data holding register, enabled by the completion strobe.

Test Plan:
1. CCW basic (M=4, W=4, phase=0): feed 1,2,3,4 on consecutive cycles → o_valid one cycle after the "4" edge; o_data = {4,3,2,1} (branch0=1); o_phase sequence 0,1,2,3,0.
2. CW basic (gp_ccw=0, M=4): feed 1,2,3,4 → o_data branch3=1, branch2=2, branch1=3, branch0=4; o_phase sequence 3,2,1,0,3.
3. Phase alignment (gp_phase=2, CCW): feed 9,9,1,2,3,4,5 → the two 9s are discarded; first frame is {4,3,2,1}; no o_valid before the "4".
4. Gapped input: i_valid pattern 1,0,0,1,1,0,1 with data −8,x,x,7,−1,x,3 → one o_valid after the last accept; o_data = {3,−1,7,−8}; sign bits intact.
5. Sync mid-frame: feed 1,2, then i_sync with data 5, then 6,7,8,9 → no o_valid for the partial frame; frame = {9,8,7,6}; o_data retains the previous frame until then.
6. Enable and reset: continuous stream; drop i_ena on the completion edge → no o_valid and state frozen; assert i_rst asynchronously mid-frame → o_data=0, o_valid=0, o_phase=start branch with no clock edge required.
